dsp_result_reader: RTL and testbench

DSP_RESULT_READER -- requirements
Module: dsp_result_reader

---
 rtl/dsp_reader_pkg.sv | 31 +++
 rtl/dsp_result_reader_byte_tx_stage.sv | 38 +++
 rtl/dsp_result_reader.sv | 170 +++++++++++++++++
 tb/tb_dsp_result_reader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dsp_reader_pkg.sv
// Shared types and constants for the DSP result reader: FSM state encoding,
// byte/word geometry, default frame header and the checksum update helper.
package dsp_reader_pkg;

  // Byte and word geometry of the captured result words.
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 64;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  // Default frame start byte.
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Frame sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HEADER  = 3'd3,
    ST_DATA    = 3'd4,
    ST_CSUM    = 3'd5
  } reader_state_t;

  // Running XOR checksum over the data bytes of a frame.
  function automatic logic [BYTE_W-1:0] csum_update(
    input logic [BYTE_W-1:0] csum,
    input logic [BYTE_W-1:0] data
  );
    return csum ^ data;
  endfunction

endpackage

// File: rtl/dsp_result_reader_byte_tx_stage.sv
// Output byte register with valid/ready handshake. A byte loaded here stays
// on tx_data with tx_valid high until the sink accepts it; the controller
// may load the following byte on the accepting edge so a continuously ready
// sink sees one byte per cycle. Outputs come straight from flops.
module byte_tx_stage
  import dsp_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_byte,
  input  logic              tx_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              accept
);

  // Handshake completes in the cycle the sink sees a valid byte and is ready.
  assign accept = tx_valid & tx_ready;

  // Output register: load a new byte, drop valid on acceptance, else hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_valid <= 1'b0;
      tx_data  <= {BYTE_W{1'b0}};
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= load_byte;
    end else if (accept) begin
      tx_valid <= 1'b0;
      tx_data  <= tx_data;
    end else begin
      tx_valid <= tx_valid;
      tx_data  <= tx_data;
    end
  end

endmodule

// File: rtl/dsp_result_reader.sv
// DSP result reader: on a start request, waits a settle time, snapshots all
// result words, then streams a frame HEADER, every snapshot byte (word 0
// first, least-significant byte first) and an XOR checksum of the data bytes
// through a valid/ready byte interface. done pulses once the checksum byte
// has been accepted; the FSM holds CSUM during that pulse so a coincident
// start is ignored.
module dsp_result_reader
  import dsp_reader_pkg::*;
#(
  parameter int         NUM_WORDS     = 5,
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [7:0] HEADER        = HEADER_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_WORDS*WORD_W-1:0] product,
  input  logic                        start,
  output logic [BYTE_W-1:0]           tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int NUM_BYTES = NUM_WORDS * BYTES_PER_WORD;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES);

  reader_state_t                 state;
  reader_state_t                 state_next;
  logic [7:0]                    settle_cnt;
  logic [7:0]                    settle_cnt_next;
  logic [IDX_W-1:0]              byte_idx;
  logic [IDX_W-1:0]              byte_idx_next;
  logic [IDX_W-1:0]              byte_idx_sel;
  logic [BYTE_W-1:0]             csum;
  logic [BYTE_W-1:0]             csum_next;
  logic [NUM_WORDS*WORD_W-1:0]   snapshot;
  logic [NUM_WORDS*WORD_W-1:0]   snapshot_next;
  logic                          done_next;
  logic [BYTE_W-1:0]             cur_byte;
  logic [BYTE_W-1:0]             following_byte;
  logic                          tx_load;
  logic [BYTE_W-1:0]             tx_load_byte;
  logic                          tx_accept;

  // Index of the byte after the current one; folded to 0 on the last byte so
  // the mux never selects outside the snapshot.
  always_comb begin
    if (byte_idx == LAST_IDX) begin
      byte_idx_sel = {IDX_W{1'b0}};
    end else begin
      byte_idx_sel = byte_idx + ONE_IDX;
    end
  end

  // Byte selection from the static snapshot by index.
  assign cur_byte       = snapshot[int'(byte_idx) * BYTE_W +: BYTE_W];
  assign following_byte = snapshot[int'(byte_idx_sel) * BYTE_W +: BYTE_W];

  // Next-state, datapath update and byte-load decisions for the frame FSM.
  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    byte_idx_next   = byte_idx;
    csum_next       = csum;
    snapshot_next   = snapshot;
    done_next       = 1'b0;
    tx_load         = 1'b0;
    tx_load_byte    = {BYTE_W{1'b0}};
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next      = ST_SETTLE;
          settle_cnt_next = SETTLE_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt <= 8'd1) begin
          state_next      = ST_CAPTURE;
          settle_cnt_next = 8'd0;
        end else begin
          settle_cnt_next = settle_cnt - 8'd1;
        end
      end
      ST_CAPTURE: begin
        snapshot_next = product;
        csum_next     = {BYTE_W{1'b0}};
        byte_idx_next = {IDX_W{1'b0}};
        tx_load       = 1'b1;
        tx_load_byte  = HEADER;
        state_next    = ST_HEADER;
      end
      ST_HEADER: begin
        if (tx_accept) begin
          tx_load      = 1'b1;
          tx_load_byte = cur_byte;
          state_next   = ST_DATA;
        end else begin
          state_next = ST_HEADER;
        end
      end
      ST_DATA: begin
        if (tx_accept) begin
          csum_next = csum_update(csum, cur_byte);
          tx_load   = 1'b1;
          if (byte_idx == LAST_IDX) begin
            byte_idx_next = {IDX_W{1'b0}};
            tx_load_byte  = csum_update(csum, cur_byte);
            state_next    = ST_CSUM;
          end else begin
            byte_idx_next = byte_idx_sel;
            tx_load_byte  = following_byte;
          end
        end else begin
          state_next = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (done) begin
          state_next = ST_IDLE;
        end else if (tx_accept) begin
          done_next = 1'b1;
        end else begin
          state_next = ST_CSUM;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Control and datapath registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      settle_cnt <= 8'd0;
      byte_idx   <= {IDX_W{1'b0}};
      csum       <= {BYTE_W{1'b0}};
      snapshot   <= {(NUM_WORDS*WORD_W){1'b0}};
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
      byte_idx   <= byte_idx_next;
      csum       <= csum_next;
      snapshot   <= snapshot_next;
      done       <= done_next;
      busy       <= (state_next != ST_IDLE);
    end
  end

  byte_tx_stage u_tx (
    .clk       (clk),
    .reset     (reset),
    .load      (tx_load),
    .load_byte (tx_load_byte),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .accept    (tx_accept)
  );

endmodule

// File: tb/tb_dsp_result_reader.sv
// Directed bench for dsp_result_reader: frames with always-ready and
// toggling sinks, identical words, product changes after capture, ignored
// starts and a mid-frame reset.
module tb_dsp_result_reader;

  localparam int NW     = 5;
  localparam int SETTLE = 4;
  localparam int NBYTES = NW * 8;

  logic              clk;
  logic              reset;
  logic [NW*64-1:0]  product;
  logic              start;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;

  int tests_run;
  int tests_failed;
  logic [7:0] got[$];

  dsp_result_reader #(
    .NUM_WORDS     (NW),
    .SETTLE_CYCLES (SETTLE),
    .HEADER        (8'hA5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .product  (product),
    .start    (start),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One frame: start pulse, drive the sink, collect accepted bytes and check
  // them against the words handed in (prod) and a hand-computed checksum.
  task automatic run_frame(input string name, input logic [NW*64-1:0] prod,
                           input bit toggle, input bit mutate, input bit extra_starts,
                           input int abort_at, input logic [7:0] exp_csum);
    logic [7:0] prev_data;
    logic [7:0] exp_byte;
    bit   stalled;
    bit   start_pending;
    bit   mid_done;
    int   first_valid;
    int   first_acc;
    int   last_acc;
    int   dones;
    int   post;
    int   extra;
    got.delete();
    product       = prod;
    tx_ready      = 1'b1;
    start         = 1'b1;
    stalled       = 1'b0;
    start_pending = 1'b0;
    mid_done      = 1'b0;
    prev_data     = 8'h00;
    first_valid   = 0;
    first_acc     = 0;
    last_acc      = 0;
    dones         = 0;
    post          = -1;
    for (int it = 1; it <= 400; it++) begin
      @(negedge clk);
      if (it == 1) begin
        start = 1'b0;
        check({name, "_busy_after_start"}, {63'd0, busy}, 64'd1);
      end
      if (start_pending) begin
        start         = 1'b0;
        start_pending = 1'b0;
      end
      if (stalled) begin
        check({name, "_stall_valid"}, {63'd0, tx_valid}, 64'd1);
        check({name, "_stall_data"}, {56'd0, tx_data}, {56'd0, prev_data});
      end
      if (tx_valid && first_valid == 0) first_valid = it;
      if (done) begin
        dones++;
        if (post < 0) post = 0;
        if (extra_starts) begin
          start         = 1'b1;
          start_pending = 1'b1;
        end
      end
      if (extra_starts && !mid_done && got.size() == 10) begin
        start         = 1'b1;
        start_pending = 1'b1;
        mid_done      = 1'b1;
      end
      if (abort_at > 0 && got.size() == abort_at) begin
        reset = 1'b0;
        @(negedge clk);
        check({name, "_abort_valid"}, {63'd0, tx_valid}, 64'd0);
        check({name, "_abort_busy"}, {63'd0, busy}, 64'd0);
        check({name, "_abort_data"}, {56'd0, tx_data}, 64'd0);
        reset    = 1'b1;
        tx_ready = 1'b1;
        extra    = 0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (tx_valid || busy) extra++;
        end
        check({name, "_abort_quiet"}, extra, 64'd0);
        return;
      end
      tx_ready = toggle ? it[0] : 1'b1;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        if (first_acc == 0) first_acc = it;
        last_acc = it;
      end
      stalled   = tx_valid && !tx_ready;
      prev_data = tx_data;
      if (mutate && first_valid != 0) begin
        for (int w = 0; w < NW * 2; w++) product[w*32 +: 32] = $urandom();
      end
      if (post >= 0) post++;
      if (post > 3) break;
    end
    start = 1'b0;
    check({name, "_done_pulses"}, dones, 64'd1);
    check({name, "_first_valid_cycle"}, first_valid, 64'(1 + SETTLE + 1));
    check({name, "_byte_count"}, got.size(), 64'(NBYTES + 2));
    check({name, "_busy_end"}, {63'd0, busy}, 64'd0);
    if (!toggle) check({name, "_no_bubbles"}, last_acc - first_acc, 64'(NBYTES + 1));
    for (int j = 0; j < got.size() && j < NBYTES + 2; j++) begin
      if (j == 0) exp_byte = 8'hA5;
      else if (j <= NBYTES) exp_byte = prod[(j-1)*8 +: 8];
      else exp_byte = exp_csum;
      check($sformatf("%s_byte%0d", name, j), {56'd0, got[j]}, {56'd0, exp_byte});
    end
  endtask

  logic [NW*64-1:0] p_ab;
  logic [NW*64-1:0] p_seq;
  logic [NW*64-1:0] p_mix;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b0;
    start    = 1'b0;
    tx_ready = 1'b0;
    product  = '0;
    p_ab     = '0;
    p_ab[63:0] = 64'h0000_0000_0000_00AB;
    for (int k = 0; k < NW; k++) p_seq[k*64 +: 64] = 64'h0102_0304_0506_0708;
    p_mix          = '0;
    p_mix[63:0]    = 64'hDEAD_BEEF_0123_4567;
    p_mix[319:256] = 64'h0000_0000_0000_00FF;

    repeat (3) @(negedge clk);
    check("rst_valid", {63'd0, tx_valid}, 64'd0);
    check("rst_data", {56'd0, tx_data}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_busy", {63'd0, busy}, 64'd0);

    run_frame("ab",     p_ab,  1'b0, 1'b0, 1'b0, 0,  8'hAB);
    run_frame("seq",    p_seq, 1'b0, 1'b0, 1'b0, 0,  8'h08);
    run_frame("toggle", p_ab,  1'b1, 1'b0, 1'b0, 0,  8'hAB);
    run_frame("mutate", p_mix, 1'b0, 1'b1, 1'b0, 0,  8'hDD);
    run_frame("restart",p_ab,  1'b0, 1'b0, 1'b1, 0,  8'hAB);
    run_frame("abort",  p_seq, 1'b0, 1'b0, 1'b0, 10, 8'h08);
    run_frame("after",  p_seq, 1'b0, 1'b0, 1'b0, 0,  8'h08);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
